// File: rtl/bsg_chip_pkg.sv
// rtl/bsg_chip_pkg.sv - chip-wide NoC constants and the injection header layout
package bsg_chip_pkg;

    localparam int flit_width_gp     = 16;
    localparam int cord_width_gp     = 5;
    localparam int len_width_gp      = 4;
    localparam int inject_arb_els_gp = 2;

    // Header flit: destination coordinate in the low bits, body-flit count above it.
    typedef struct packed {
        logic [flit_width_gp-len_width_gp-cord_width_gp-1:0] pad;
        logic [len_width_gp-1:0]                             len;
        logic [cord_width_gp-1:0]                            cord;
    } bsg_noc_inject_hdr_s;

endpackage

// File: rtl/bsg_noc_inject_rr_pick.sv
// rtl/bsg_noc_inject_rr_pick.sv - combinational round-robin picker scanning upward from last+1
module bsg_noc_inject_rr_pick
    import bsg_chip_pkg::*;
#(
    parameter int els_p = 2,
    parameter int lg_w  = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic [els_p-1:0] v_i,
    input  logic [lg_w-1:0]  last_i,
    output logic [lg_w-1:0]  pick_o,
    output logic             any_v_o
);

    always_comb begin
        int w_j;
        w_j     = 0;
        pick_o  = '0;
        any_v_o = 1'b0;
        for (int i = 1; i <= els_p; i++) begin
            w_j = int'(last_i) + i;
            if (w_j >= els_p) begin
                w_j = w_j - els_p;
            end
            if (!any_v_o && v_i[w_j[lg_w-1:0]]) begin
                any_v_o = 1'b1;
                pick_o  = w_j[lg_w-1:0];
            end
        end
    end

endmodule

// File: rtl/bsg_noc_wormhole_inject_arb.sv
// rtl/bsg_noc_wormhole_inject_arb.sv - packet-locked round-robin arbiter for a wormhole injection port
// Optional stall watchdog: BSG_NOC_INJECT_ARB_WATCHDOG_EN
module bsg_noc_wormhole_inject_arb
    import bsg_chip_pkg::*;
#(
    parameter int els_p         = 2,
    parameter int flit_width_p  = flit_width_gp,
    parameter int cord_width_p  = cord_width_gp,
    parameter int len_width_p   = len_width_gp,
    parameter int stall_width_p = 10
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [els_p-1:0]                v_i,
    input  logic [els_p*flit_width_p-1:0]   data_i,
    output logic [els_p-1:0]                ready_and_o,
    output logic                            v_o,
    output logic [flit_width_p-1:0]         data_o,
    input  logic                            ready_and_i,
    output logic                            error_o
);

    localparam int lg_w = (els_p > 1) ? $clog2(els_p) : 1;

    typedef enum logic {
        e_idle,
        e_lock
    } state_e;

    state_e                 r_state;
    logic [len_width_p-1:0] r_count;
    logic [lg_w-1:0]        r_gnt;
    logic [lg_w-1:0]        r_last;

    logic [lg_w-1:0]         w_pick;
    logic                    w_any_v;
    logic [lg_w-1:0]         w_sel;
    logic                    w_hs;
    logic [len_width_p-1:0]  w_len;
    logic [els_p-1:0]        w_ready;
    logic [flit_width_p-1:0] w_data [els_p];

    for (genvar g = 0; g < els_p; g++) begin : g_slice
        assign w_data[g] = data_i[g*flit_width_p +: flit_width_p];
    end

    bsg_noc_inject_rr_pick #(
        .els_p (els_p),
        .lg_w  (lg_w)
    ) u_pick (
        .v_i     (v_i),
        .last_i  (r_last),
        .pick_o  (w_pick),
        .any_v_o (w_any_v)
    );

    assign w_sel  = (r_state == e_lock) ? r_gnt : w_pick;
    assign v_o    = ~reset_i & ((r_state == e_lock) ? v_i[r_gnt] : w_any_v);
    assign data_o = w_data[w_sel];
    assign w_hs   = v_o & ready_and_i;
    assign w_len  = data_o[cord_width_p +: len_width_p];

    always_comb begin
        w_ready = '0;
        if (!reset_i) begin
            w_ready[w_sel] = ready_and_i;
        end
    end
    assign ready_and_o = w_ready;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_idle;
            r_count <= '0;
            r_gnt   <= '0;
            r_last  <= lg_w'(els_p - 1);
        end else begin
            case (r_state)
                e_idle: begin
                    if (w_hs) begin
                        r_last <= w_pick;
                        // A zero-length header is a complete packet; stay open for the next pick.
                        if (w_len != '0) begin
                            r_gnt   <= w_pick;
                            r_count <= w_len;
                            r_state <= e_lock;
                        end
                    end
                end
                e_lock: begin
                    if (w_hs) begin
                        r_count <= r_count - 1'b1;
                        if (r_count == len_width_p'(1)) begin
                            r_state <= e_idle;
                        end
                    end
                end
                default: r_state <= e_idle;
            endcase
        end
    end

`ifdef BSG_NOC_INJECT_ARB_WATCHDOG_EN
    logic [stall_width_p-1:0] r_stall;
    logic                     r_error;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stall <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state != e_lock || w_hs) begin
                r_stall <= '0;
            end else if (!(&r_stall)) begin
                r_stall <= r_stall + 1'b1;
            end
            if (&r_stall) begin
                r_error <= 1'b1;
            end
        end
    end

    assign error_o = r_error;
`else
    logic w_unused_stall;
    assign w_unused_stall = (stall_width_p != 0);
    assign error_o        = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_noc_wormhole_inject_arb.sv
// tb/tb_bsg_noc_wormhole_inject_arb.sv - directed vector bench for the injection arbiter
module tb_bsg_noc_wormhole_inject_arb;

    localparam int FW = 16;
`ifdef BSG_NOC_INJECT_ARB_WATCHDOG_EN
    localparam int SW = 4;
    localparam logic WD = 1'b1;
`else
    localparam int SW = 10;
    localparam logic WD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i;
    logic [1:0]    v_i;
    logic [2*FW-1:0] data_i;
    logic [1:0]    ready_and_o;
    logic          v_o;
    logic [FW-1:0] data_o;
    logic          ready_and_i;
    logic          error_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bsg_noc_wormhole_inject_arb #(
        .els_p         (2),
        .flit_width_p  (FW),
        .cord_width_p  (5),
        .len_width_p   (4),
        .stall_width_p (SW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .v_i         (v_i),
        .data_i      (data_i),
        .ready_and_o (ready_and_o),
        .v_o         (v_o),
        .data_o      (data_o),
        .ready_and_i (ready_and_i),
        .error_o     (error_o)
    );

    typedef struct {
        logic          rst;
        logic [1:0]    v;
        logic [FW-1:0] d0;
        logic [FW-1:0] d1;
        logic          rdy;
        logic          ev;
        logic [FW-1:0] ed;
        logic [1:0]    er;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [FW-1:0] hdr(input logic [6:0] tag, input logic [3:0] len);
        return {tag, len, 5'd3};
    endfunction

    function automatic logic [FW-1:0] body(input logic [7:0] tag);
        return {8'hB0, tag};
    endfunction

    function automatic void add(input logic rst, input logic [1:0] v, input logic [FW-1:0] d0,
                                input logic [FW-1:0] d1, input logic rdy, input logic ev,
                                input logic [FW-1:0] ed, input logic [1:0] er);
        vec_t t;
        t.rst = rst; t.v = v; t.d0 = d0; t.d1 = d1; t.rdy = rdy;
        t.ev = ev; t.ed = ed; t.er = er;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, sample 2 time units later, well before the rising edge.
    task automatic step(input logic rst, input logic [1:0] v, input logic [FW-1:0] d0,
                        input logic [FW-1:0] d1, input logic rdy);
        @(negedge clk);
        reset_i = rst; v_i = v; data_i = {d1, d0}; ready_and_i = rdy;
        #2;
    endtask

    initial begin
        reset_i = 1'b1; v_i = '0; data_i = '0; ready_and_i = 1'b0;

        // reset: outputs quiet even with requests pending
        add(1, 2'b11, hdr(1, 3), hdr(2, 3), 1, 0, '0, 2'b00);
        add(1, 2'b11, hdr(1, 3), hdr(2, 3), 1, 0, '0, 2'b00);
        // single requester len=3 packet
        add(0, 2'b01, hdr(1, 3), '0, 1, 1, hdr(1, 3), 2'b01);
        add(0, 2'b01, body(1),   '0, 1, 1, body(1),   2'b01);
        add(0, 2'b01, body(2),   '0, 1, 1, body(2),   2'b01);
        add(0, 2'b01, body(3),   '0, 1, 1, body(3),   2'b01);
        add(0, 2'b00, '0,        '0, 0, 0, '0,        2'b00);
        // requester 1 waits while requester 0 holds a len=2 packet
        add(0, 2'b01, hdr(3, 2), hdr(4, 0), 1, 1, hdr(3, 2), 2'b01);
        add(0, 2'b11, body(4),   hdr(4, 0), 1, 1, body(4),   2'b01);
        add(0, 2'b11, body(5),   hdr(4, 0), 1, 1, body(5),   2'b01);
        add(0, 2'b10, '0,        hdr(4, 0), 1, 1, hdr(4, 0), 2'b10);
        // both busy with len=1 packets: grants alternate by packet
        add(0, 2'b11, hdr(5, 1), hdr(6, 1), 1, 1, hdr(5, 1), 2'b01);
        add(0, 2'b11, body(6),   hdr(6, 1), 1, 1, body(6),   2'b01);
        add(0, 2'b11, hdr(5, 1), hdr(6, 1), 1, 1, hdr(6, 1), 2'b10);
        add(0, 2'b11, hdr(5, 1), body(7),   1, 1, body(7),   2'b10);
        add(0, 2'b11, hdr(5, 1), hdr(6, 1), 1, 1, hdr(5, 1), 2'b01);
        add(0, 2'b11, body(8),   hdr(6, 1), 1, 1, body(8),   2'b01);
        // len=0 headers from both: one flit per cycle alternating, no lock
        add(0, 2'b11, hdr(7, 0), hdr(8, 0), 1, 1, hdr(8, 0), 2'b10);
        add(0, 2'b11, hdr(7, 0), hdr(8, 0), 1, 1, hdr(7, 0), 2'b01);
        add(0, 2'b11, hdr(7, 0), hdr(8, 0), 1, 1, hdr(8, 0), 2'b10);
        // mid-packet stalls: router back-pressure then requester drop
        add(0, 2'b01, hdr(9, 2), hdr(10, 0), 1, 1, hdr(9, 2), 2'b01);
        for (int i = 0; i < 5; i++)
            add(0, 2'b11, body(9), hdr(10, 0), 0, 1, body(9), 2'b00);
        for (int i = 0; i < 3; i++)
            add(0, 2'b10, body(9), hdr(10, 0), 1, 0, '0, 2'b01);
        add(0, 2'b11, body(9),  hdr(10, 0), 1, 1, body(9),    2'b01);
        add(0, 2'b11, body(10), hdr(10, 0), 1, 1, body(10),   2'b01);
        add(0, 2'b11, '0,       hdr(10, 0), 1, 1, hdr(10, 0), 2'b10);
        // reset mid-packet abandons the lock and restores requester 0 priority
        add(0, 2'b01, hdr(11, 3), '0,         1, 1, hdr(11, 3), 2'b01);
        add(1, 2'b01, body(11),   '0,         1, 0, '0,         2'b00);
        add(0, 2'b10, '0,         hdr(12, 0), 1, 1, hdr(12, 0), 2'b10);
        add(0, 2'b11, hdr(13, 0), hdr(12, 0), 1, 1, hdr(13, 0), 2'b01);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].d0, vecs[i].d1, vecs[i].rdy);
            chk($sformatf("v_o[%0d]", i), 32'(v_o), 32'(vecs[i].ev));
            chk($sformatf("ready_and_o[%0d]", i), 32'(ready_and_o), 32'(vecs[i].er));
            chk($sformatf("error_o[%0d]", i), 32'(error_o), 32'(1'b0));
            if (vecs[i].ev)
                chk($sformatf("data_o[%0d]", i), 32'(data_o), 32'(vecs[i].ed));
        end

        // maximum length packet: 15 body flits, then the port opens again
        step(0, 2'b01, hdr(14, 15), '0, 1);
        chk("max_hdr", 32'(data_o), 32'(hdr(14, 15)));
        for (int i = 0; i < 15; i++) begin
            step(0, 2'b11, body(8'(i)), hdr(15, 0), 1);
            chk($sformatf("max_body%0d", i), 32'({ready_and_o, data_o}), 32'({2'b01, body(8'(i))}));
        end
        step(0, 2'b11, '0, hdr(15, 0), 1);
        chk("max_release", 32'({ready_and_o, data_o}), 32'({2'b10, hdr(15, 0)}));

        // watchdog: 16 cycles locked with no handshake
        step(0, 2'b01, hdr(16, 2), '0, 1);
        chk("wd_hdr", 32'(ready_and_o), 32'(2'b01));
        for (int i = 0; i < 15; i++)
            step(0, 2'b01, body(1), '0, 0);
        chk("wd_before_sat", 32'(error_o), 32'(1'b0));
        step(0, 2'b01, body(1), '0, 0);
        step(0, 2'b01, body(1), '0, 0);
        chk("wd_error", 32'(error_o), 32'(WD));
        step(0, 2'b01, body(1), '0, 1);
        step(0, 2'b01, body(2), '0, 1);
        step(0, 2'b00, '0, '0, 0);
        chk("wd_sticky", 32'(error_o), 32'(WD));
        step(1, 2'b00, '0, '0, 0);
        step(0, 2'b00, '0, '0, 0);
        chk("wd_reset", 32'(error_o), 32'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsg_noc_wormhole_inject_arb.md
# bsg_noc_wormhole_inject_arb

Round-robin, packet-locked arbiter that shares a single wormhole router injection (proc) port among `els_p` requesters. Arbitration happens on header flits only; once a header is accepted, the winner holds the port until its last body flit transfers, so wormhole packets are never interleaved. It sits between on-chip traffic sources and the `P` input link of `bsg_wormhole_router` in `bsg_chip`. The data path is zero-latency and pass-through, with no flit storage.

## Interface
Parameters:
- `els_p`, 2: number of requesters; must be ≥1.
- `flit_width_p`, `flit_width_gp`: flit width.
- `cord_width_p`, `cord_width_gp`: width of the destination coordinate in header bits `[0 +: cord_width_p]`.
- `len_width_p`, `len_width_gp`: width of the body-flit count in header bits `[cord_width_p +: len_width_p]`.
- `stall_width_p`, 10: watchdog counter width; used only with the watchdog compiled in.

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `v_i` in `els_p`: per-requester flit valid.
- `data_i` in `els_p*flit_width_p`: per-requester flit.
- `ready_and_o` out `els_p`: per-requester accept.
- `v_o` out 1: valid to the router link.
- `data_o` out `flit_width_p`: flit to the router link.
- `ready_and_i` in 1: router accept.
- `error_o` out 1: sticky watchdog error.

## Operation
- A handshake on a port occurs when `v` and `ready_and` are both high in the same cycle.
- States:
  - IDLE: every valid requester is presenting a header.
  - LOCK: `count` body flits remain for granted requester `gnt`.
- IDLE pick: the first set `v_i[k]` scanning from `last+1` upward, wrapping modulo `els_p`. With no valid requester, `v_o`=0.
- IDLE outputs:
  - `v_o`=`v_i[pick]`, `data_o`=`data_i[pick]`.
  - `ready_and_o[pick]`=`ready_and_i`; all other `ready_and_o` bits are 0.
- IDLE, on output handshake:
  - `last`←pick. The pointer advances only on a header handshake.
  - If len≠0: `gnt`←pick, `count`←len, go to LOCK.
  - If len=0: stay in IDLE; a single-flit packet is complete.
- Without a handshake in IDLE, the pick is recomputed every cycle. A stalled header may lose its pick to a different requester.
- LOCK outputs:
  - `v_o`=`v_i[gnt]`, `data_o`=`data_i[gnt]`.
  - `ready_and_o[gnt]`=`ready_and_i`; all other bits are 0.
  - Body flits are not decoded.
- LOCK, on handshake: `count`←`count`-1. A handshake at `count`=1 returns to IDLE.
- `count` is `len_width_p` bits. The maximum length (2^`len_width_p`-1) is legal; there is no wrap-around.
- Requesters may deassert `v_i` mid-packet. That is a stall: the block holds LOCK and the port is not released.
- `data_o` is don't-care when `v_o`=0.

## Timing
- Combinational paths:
  - `v_i`/`data_i` → `v_o`/`data_o`.
  - `ready_and_i` → `ready_and_o`.
- Latency is 0 cycles; throughput is 1 flit/cycle.
- State updates on the `clk_i` edge following a handshake. The cycle after a last-flit handshake is IDLE, so back-to-back packets run with no bubble.
- Reset values (while `reset_i`=1):
  - State IDLE, `count`=0, `last`=`els_p`-1 (requester 0 has first priority).
  - `v_o`=0, `ready_and_o`=0, `error_o`=0.
- Reset mid-packet abandons the packet. Requesters must also be reset.
- `els_p`=1: pick is always 0, and the pointer logic is trivially constant.

## Configuration
- `BSG_NOC_INJECT_ARB_WATCHDOG_EN` defined:
  - A `stall_width_p`-bit counter clears on every LOCK handshake and on entry to LOCK.
  - It increments each LOCK cycle without a handshake and saturates.
  - When saturated, `error_o`←1, sticky until reset.
  - The counter is held at 0 in IDLE.
- Macro undefined: no counter is instantiated and `error_o` is tied to 0.

## Structure
- `bsg_chip_pkg` gains a `bsg_noc_inject_hdr_s` packed typedef.
  - Fields: `cord` (`cord_width_gp`), `len` (`len_width_gp`), and pad to `flit_width_gp`.
  - Also add the `inject_arb_els_gp` constant.
- The state enum (`e_idle`, `e_lock`) is local to the module.
- One sub-module, `bsg_noc_inject_rr_pick`: a combinational round-robin picker taking `v_i` and `last`, producing `pick` and `any_v`.

## Test plan
- `els_p`=2, only requester 0 sends a header with len=3 → 4 flits pass in 4 cycles; `ready_and_o`=2'b01 throughout; final state IDLE.
- Both requesters valid continuously with len=1 packets → grants alternate 0,1,0,1 by packet; flits never interleave within a packet.
- Requester 1 raises a header while requester 0 is in LOCK with len=2 → `ready_and_o[1]`=0 until requester 0's 2nd body flit; requester 1 is granted the next cycle.
- len=0 headers from both requesters back-to-back → one flit per cycle, alternating 0,1; never enters LOCK.
- `ready_and_i`=0 for 5 cycles mid-packet, plus `v_i[gnt]` dropped for 3 cycles → no flit lost or duplicated; `count` is unchanged across the stall.
- Watchdog build, `stall_width_p`=4: hold LOCK with no handshake for 16 cycles → `error_o`=1 and it stays high; `reset_i` clears it to 0.
